// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: shares one serial 16-bit binary-to-BCD converter between
// NREQ requesters. Grants rotate round-robin, the converter handshake is
// sequenced by a four-state FSM, and a watchdog aborts a stuck conversion.
module bcd_conv_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 31,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req,
  input  logic [16*NREQ-1:0] bin,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [19:0]        bcd_out,
  output logic [IW-1:0]      done_id,
  output logic               conv_en,
  output logic [15:0]        conv_bin,
  input  logic               conv_busy,
  input  logic               conv_fin,
  input  logic [3:0]         conv_bcd0,
  input  logic [3:0]         conv_bcd1,
  input  logic [3:0]         conv_bcd2,
  input  logic [3:0]         conv_bcd3,
  input  logic [3:0]         conv_bcd4
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic          pick_valid;
  logic [7:0]    wdog;
  logic          wdog_expired;

  assign wdog_expired = (wdog == 8'(TIMEOUT));

  // Round-robin search: first requesting index at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value held and no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_valid) state_nxt = S_ISSUE;
      S_ISSUE: if (!conv_busy) state_nxt = S_WAIT;
      S_WAIT:  if (conv_fin || wdog_expired) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Converter start is combinational so it drops the same cycle busy rises.
  always_comb begin
    conv_en = (state == S_ISSUE) && !conv_busy;
  end

  // Datapath: grant latch, operand, watchdog, result holding and pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack      <= '0;
      done     <= '0;
      err      <= '0;
      bcd_out  <= '0;
      done_id  <= '0;
      conv_bin <= '0;
      rr_ptr   <= '0;
      gnt      <= '0;
      wdog     <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt           <= pick_idx;
            conv_bin      <= bin[{pick_idx, 4'b0000} +: 16];
            ack[pick_idx] <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!conv_busy) wdog <= '0;
        end
        S_WAIT: begin
          if (conv_fin) begin
            bcd_out   <= {conv_bcd4, conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0};
            done_id   <= gnt;
            done[gnt] <= 1'b1;
          end else if (wdog_expired) begin
            // Abort: report the requester but keep the previous result.
            done_id  <= gnt;
            err[gnt] <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        S_DONE: begin
          if (gnt == IW'(NREQ - 1)) rr_ptr <= '0;
          else                      rr_ptr <= gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: behavioural converter model,
// scoreboard of expected results, directed steps in one initial block.
module tb_bcd_conv_arbiter;

  localparam int NREQ    = 4;
  localparam int IW      = 2;
  localparam int TIMEOUT = 31;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [16*NREQ-1:0] bin = '0;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic [19:0]        bcd_out;
  logic [IW-1:0]      done_id;
  logic               conv_en;
  logic [15:0]        conv_bin;
  logic               conv_busy;
  logic               conv_fin;
  logic [3:0]         conv_bcd0, conv_bcd1, conv_bcd2, conv_bcd3, conv_bcd4;

  bcd_conv_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .bin       (bin),
    .ack       (ack),
    .done      (done),
    .err       (err),
    .bcd_out   (bcd_out),
    .done_id   (done_id),
    .conv_en   (conv_en),
    .conv_bin  (conv_bin),
    .conv_busy (conv_busy),
    .conv_fin  (conv_fin),
    .conv_bcd0 (conv_bcd0),
    .conv_bcd1 (conv_bcd1),
    .conv_bcd2 (conv_bcd2),
    .conv_bcd3 (conv_bcd3),
    .conv_bcd4 (conv_bcd4)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Converter model: start on conv_en, busy for 16 cycles, fin one cycle.
  // stall_busy forces extra busy; no_fin makes it ignore starts entirely.
  logic        stall_busy = 1'b0;
  logic        no_fin     = 1'b0;
  logic        m_busy;
  logic        m_fin;
  logic [4:0]  m_cnt;
  logic [15:0] m_val;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_busy <= 1'b0;
      m_fin  <= 1'b0;
      m_cnt  <= '0;
      m_val  <= '0;
    end else begin
      m_fin <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 5'd0) begin
          m_busy <= 1'b0;
          m_fin  <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 5'd1;
        end
      end else if (conv_en && !no_fin) begin
        m_busy <= 1'b1;
        m_cnt  <= 5'd15;
        m_val  <= conv_bin;
      end
    end
  end

  assign conv_busy = m_busy | stall_busy;
  assign conv_fin  = m_fin;
  assign conv_bcd0 = 4'(m_val % 16'd10);
  assign conv_bcd1 = 4'((m_val / 16'd10) % 16'd10);
  assign conv_bcd2 = 4'((m_val / 16'd100) % 16'd10);
  assign conv_bcd3 = 4'((m_val / 16'd1000) % 16'd10);
  assign conv_bcd4 = 4'(m_val / 16'd10000);

  typedef struct {
    logic [IW-1:0] id;
    logic [19:0]   bcd;
    bit            is_err;
  } exp_t;

  exp_t sb[$];

  int          total = 0;
  int          bad   = 0;
  int unsigned ack_cyc;
  int unsigned res_cyc;
  int unsigned t0;
  int unsigned prev;
  int          pulses;

  function automatic logic [19:0] to_bcd(int v);
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_ack"},      ack, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_err"},      err, 0);
    check({tag, "_bcd_out"},  bcd_out, 0);
    check({tag, "_done_id"},  done_id, 0);
    check({tag, "_conv_bin"}, conv_bin, 0);
    check({tag, "_conv_en"},  conv_en, 0);
  endtask

  task automatic wait_ack(logic [NREQ-1:0] exp, string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (ack == '0 && n < 30);
    ack_cyc = cyc;
    check(tag, ack, exp);
  endtask

  task automatic wait_result(int budget, string tag);
    int              n = 0;
    exp_t            e;
    logic [NREQ-1:0] oh;
    do begin
      @(negedge CLK);
      n++;
    end while (done == '0 && err == '0 && n < budget);
    res_cyc = cyc;
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, done | err, 0);
    end else begin
      e  = sb.pop_front();
      oh = NREQ'(1) << e.id;
      check({tag, "_done"},    done, e.is_err ? {NREQ{1'b0}} : oh);
      check({tag, "_err"},     err, e.is_err ? oh : {NREQ{1'b0}});
      check({tag, "_done_id"}, done_id, e.id);
      check({tag, "_bcd_out"}, bcd_out, e.bcd);
      check({tag, "_ack_low"}, ack, 0);
    end
  endtask

  task automatic issue_one(int id, logic [15:0] v, logic [19:0] exp_bcd, bit exp_err);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << id;
    bin[16*id +: 16] = v;
    req = oh;
    sb.push_back('{id: IW'(id), bcd: exp_bcd, is_err: exp_err});
    wait_ack(oh, "ack");
    check("conv_bin", conv_bin, v);
    req = '0;
  endtask

  initial begin
    // Reset state.
    #2;
    check_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    // Single request with full latency check.
    issue_one(0, 16'd12345, 20'h12345, 1'b0);
    check("ack_conv_en", conv_en, 1);
    t0 = ack_cyc;
    wait_result(30, "single");
    check("lat_single", res_cyc - t0, 18);

    // Maximum operand.
    issue_one(2, 16'hFFFF, 20'h65535, 1'b0);
    wait_result(30, "max");

    // Timeout: err pulse, result held, then normal service resumes.
    no_fin = 1'b1;
    issue_one(3, 16'd4242, 20'h65535, 1'b1);
    t0 = ack_cyc;
    wait_result(45, "tmo");
    check("lat_tmo", res_cyc - t0, 33);
    no_fin = 1'b0;
    issue_one(1, 16'd0, 20'h00000, 1'b0);
    wait_result(30, "zero");
    issue_one(3, 16'd9999, 20'h09999, 1'b0);
    wait_result(30, "r3");

    // Round-robin with all requests held, then 1010.
    bin = {16'd65000, 16'd100, 16'd9876, 16'd4321};
    sb.push_back('{id: 2'd0, bcd: to_bcd(4321),  is_err: 1'b0});
    sb.push_back('{id: 2'd1, bcd: to_bcd(9876),  is_err: 1'b0});
    sb.push_back('{id: 2'd2, bcd: to_bcd(100),   is_err: 1'b0});
    sb.push_back('{id: 2'd3, bcd: to_bcd(65000), is_err: 1'b0});
    sb.push_back('{id: 2'd0, bcd: to_bcd(4321),  is_err: 1'b0});
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_result(30, "rr");
      if (i > 0) check("rr_gap", res_cyc - prev, 20);
      prev = res_cyc;
    end
    req = 4'b1010;
    sb.push_back('{id: 2'd1, bcd: to_bcd(9876),  is_err: 1'b0});
    sb.push_back('{id: 2'd3, bcd: to_bcd(65000), is_err: 1'b0});
    sb.push_back('{id: 2'd1, bcd: to_bcd(9876),  is_err: 1'b0});
    for (int i = 0; i < 3; i++) begin
      wait_result(30, "rr2");
      check("rr2_gap", res_cyc - prev, 20);
      prev = res_cyc;
    end
    req = '0;

    // Busy stall: five busy ISSUE cycles, single ack, start in the sixth.
    stall_busy = 1'b1;
    bin[16 +: 16] = 16'd2024;
    sb.push_back('{id: 2'd1, bcd: 20'h02024, is_err: 1'b0});
    req = 4'b0010;
    wait_ack(4'b0010, "stall_ack");
    check("stall_en_0", conv_en, 0);
    req = '0;
    for (int i = 1; i < 5; i++) begin
      @(negedge CLK);
      check("stall_en", conv_en, 0);
      check("stall_ack_once", ack, 0);
    end
    @(posedge CLK);
    #1 stall_busy = 1'b0;
    @(negedge CLK);
    check("stall_en_6", conv_en, 1);
    check("stall_ack_6", ack, 0);
    wait_result(30, "stall");

    // Reset mid-WAIT: everything clears, no pulse, rr restarts at 0.
    bin[32 +: 16] = 16'd5555;
    req = 4'b0100;
    wait_ack(4'b0100, "rst_ack");
    req = '0;
    repeat (9) @(negedge CLK);
    #1 RST = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      if (done != '0 || err != '0) pulses++;
    end
    check("rst_no_pulse", pulses, 0);
    bin = {16'd271, 16'd0, 16'd0, 16'd31415};
    sb.push_back('{id: 2'd0, bcd: 20'h31415, is_err: 1'b0});
    sb.push_back('{id: 2'd3, bcd: 20'h00271, is_err: 1'b0});
    req = 4'b1001;
    wait_ack(4'b0001, "post_rst_ack0");
    req = 4'b1000;
    wait_result(30, "post_rst0");
    wait_ack(4'b1000, "post_rst_ack3");
    req = '0;
    wait_result(30, "post_rst3");

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
